// File: rtl/prefetch_pkg.sv
// Shared types and default parameters for the instruction prefetch queue.
package prefetch_pkg;

    localparam int PF_DEF_DEPTH  = 8;
    localparam int PF_DEF_ADDR_W = 32;
    localparam int PF_DEF_DATA_W = 64;
    localparam int PF_DEF_TAG_W  = 4;
    localparam int PF_DEF_STRIDE = 8;
    localparam int PF_STATE_W    = 2;

    typedef enum logic [PF_STATE_W-1:0] {
        ST_EMPTY   = 2'd0,
        ST_PENDING = 2'd1,
        ST_READY   = 2'd2
    } entry_state_e;

    typedef struct packed {
        logic [PF_DEF_ADDR_W-1:0] addr;
        logic [PF_DEF_TAG_W-1:0]  tag;
        logic [PF_DEF_DATA_W-1:0] data;
        entry_state_e             state;
    } pf_entry_t;

endpackage

// File: rtl/pf_tag_cam.sv
// Response-tag CAM: finds the PENDING entry whose tag equals the response tag.
module pf_tag_cam
    import prefetch_pkg::*;
#(
    parameter int DEPTH = PF_DEF_DEPTH,
    parameter int TAG_W = PF_DEF_TAG_W
) (
    input  logic [DEPTH*TAG_W-1:0]      i_tags,
    input  logic [DEPTH*PF_STATE_W-1:0] i_states,
    input  logic [TAG_W-1:0]            i_resp_tag,
    output logic [DEPTH-1:0]            o_match,
    output logic                        o_match_valid
);

    logic [DEPTH-1:0] w_match_raw;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
            assign w_match_raw[gi] = (i_resp_tag != '0)
                && (i_tags[gi*TAG_W +: TAG_W] == i_resp_tag)
                && (i_states[gi*PF_STATE_W +: PF_STATE_W] == ST_PENDING);
        end
    endgenerate

    // Keep only the lowest matching entry so the vector is always one-hot.
    assign o_match       = w_match_raw & (~w_match_raw + DEPTH'(1));
    assign o_match_valid = |w_match_raw;

endmodule

// File: rtl/instr_prefetch_queue.sv
// Sequential instruction prefetcher: a circular queue of outstanding/ready lines
// served in order to demand fetches, flushed and re-aimed on any mismatch.
module instr_prefetch_queue
    import prefetch_pkg::*;
#(
    parameter int DEPTH  = PF_DEF_DEPTH,
    parameter int ADDR_W = PF_DEF_ADDR_W,
    parameter int DATA_W = PF_DEF_DATA_W,
    parameter int TAG_W  = PF_DEF_TAG_W,
    parameter int STRIDE = PF_DEF_STRIDE
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_enable,
    input  logic                     i_fetch_valid,
    input  logic [ADDR_W-1:0]        i_fetch_addr,
    output logic                     o_fetch_hit,
    output logic [DATA_W-1:0]        o_fetch_data,
    output logic                     o_mem_req_valid,
    output logic [ADDR_W-1:0]        o_mem_req_addr,
    input  logic [TAG_W-1:0]         i_mem_req_tag,
    input  logic [TAG_W-1:0]         i_mem_resp_tag,
    input  logic [DATA_W-1:0]        i_mem_resp_data,
    output logic [$clog2(DEPTH):0]   o_occupancy
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [ADDR_W-1:0] r_next_addr;
    entry_state_e      r_state [DEPTH];
    logic [ADDR_W-1:0] r_addr  [DEPTH];
    logic [TAG_W-1:0]  r_tag   [DEPTH];
    logic [DATA_W-1:0] r_data  [DEPTH];

    logic [IW-1:0]                 w_head_idx;
    logic [IW-1:0]                 w_tail_idx;
    logic                          w_empty;
    logic                          w_full;
    logic                          w_redirect;
    logic                          w_hit;
    logic                          w_req_valid;
    logic                          w_alloc;
    logic [DEPTH*TAG_W-1:0]        w_tags_flat;
    logic [DEPTH*PF_STATE_W-1:0]   w_states_flat;
    logic [DEPTH-1:0]              w_match;
    logic                          w_match_valid;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_flat
            assign w_tags_flat[gi*TAG_W +: TAG_W]             = r_tag[gi];
            assign w_states_flat[gi*PF_STATE_W +: PF_STATE_W] = r_state[gi];
        end
    endgenerate

    pf_tag_cam #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_cam (
        .i_tags        (w_tags_flat),
        .i_states      (w_states_flat),
        .i_resp_tag    (i_mem_resp_tag),
        .o_match       (w_match),
        .o_match_valid (w_match_valid)
    );

    assign w_head_idx = r_head[IW-1:0];
    assign w_tail_idx = r_tail[IW-1:0];
    assign w_empty    = (r_head == r_tail);
    assign w_full     = (w_head_idx == w_tail_idx) && (r_head[IW] != r_tail[IW]);

    assign w_redirect = i_fetch_valid &&
        (w_empty ? (i_fetch_addr != r_next_addr) : (r_addr[w_head_idx] != i_fetch_addr));

    // Hit is taken from registered state only, so a response never bypasses to the fetch.
    assign w_hit = i_fetch_valid && !w_empty && (r_state[w_head_idx] == ST_READY)
                && (r_addr[w_head_idx] == i_fetch_addr);

    // Full is sampled before this cycle's pop: a freed slot is reusable only next cycle.
    assign w_req_valid = i_rst_n && i_enable && !w_full && !w_redirect;
    assign w_alloc     = w_req_valid && (i_mem_req_tag != '0);

    assign o_fetch_hit     = w_hit;
    assign o_fetch_data    = r_data[w_head_idx];
    assign o_mem_req_valid = w_req_valid;
    assign o_mem_req_addr  = r_next_addr;
    assign o_occupancy     = r_tail - r_head;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_next_addr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i] <= ST_EMPTY;
                r_addr[i]  <= '0;
                r_tag[i]   <= '0;
                r_data[i]  <= '0;
            end
        end else if (w_redirect) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_next_addr <= i_fetch_addr;
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i] <= ST_EMPTY;
            end
        end else begin
            if (w_match_valid) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (w_match[i]) begin
                        r_state[i] <= ST_READY;
                        r_data[i]  <= i_mem_resp_data;
                    end
                end
            end
            if (w_hit) begin
                r_state[w_head_idx] <= ST_EMPTY;
                r_head              <= r_head + PW'(1);
            end
            if (w_alloc) begin
                r_state[w_tail_idx] <= ST_PENDING;
                r_addr[w_tail_idx]  <= r_next_addr;
                r_tag[w_tail_idx]   <= i_mem_req_tag;
                r_tail              <= r_tail + PW'(1);
                r_next_addr         <= r_next_addr + ADDR_W'(STRIDE);
            end
        end
    end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: directed vector table plus randomized run against a queue model.
module tb_instr_prefetch_queue;
    import prefetch_pkg::*;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int TAG_W  = 4;
    localparam int STRIDE = 8;
    localparam int OCC_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              fv = 1'b0;
    logic [ADDR_W-1:0] fa = '0;
    logic [TAG_W-1:0]  rtag = '0;
    logic [TAG_W-1:0]  stag = '0;
    logic [DATA_W-1:0] sdata = '0;
    logic              o_fetch_hit;
    logic [DATA_W-1:0] o_fetch_data;
    logic              o_mem_req_valid;
    logic [ADDR_W-1:0] o_mem_req_addr;
    logic [OCC_W-1:0]  o_occupancy;

    always #5 clk = ~clk;

    instr_prefetch_queue #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W),
        .STRIDE (STRIDE)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_enable        (en),
        .i_fetch_valid   (fv),
        .i_fetch_addr    (fa),
        .o_fetch_hit     (o_fetch_hit),
        .o_fetch_data    (o_fetch_data),
        .o_mem_req_valid (o_mem_req_valid),
        .o_mem_req_addr  (o_mem_req_addr),
        .i_mem_req_tag   (rtag),
        .i_mem_resp_tag  (stag),
        .i_mem_resp_data (sdata),
        .o_occupancy     (o_occupancy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic              rst;
        logic              en;
        logic              fv;
        logic [ADDR_W-1:0] fa;
        logic [TAG_W-1:0]  rtag;
        logic [TAG_W-1:0]  stag;
        logic [DATA_W-1:0] sdata;
        logic              e_hit;
        logic [DATA_W-1:0] e_data;
        logic              e_rv;
        logic [ADDR_W-1:0] e_addr;
        logic [OCC_W-1:0]  e_occ;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic f, input logic [31:0] a,
                       input logic [3:0] rt, input logic [3:0] st, input logic [63:0] sd,
                       input logic eh, input logic [63:0] ed, input logic erv,
                       input logic [31:0] ea, input logic [3:0] eo);
        vec_t v;
        v.rst = r; v.en = e; v.fv = f; v.fa = a; v.rtag = rt; v.stag = st; v.sdata = sd;
        v.e_hit = eh; v.e_data = ed; v.e_rv = erv; v.e_addr = ea; v.e_occ = eo;
        vecs.push_back(v);
    endtask

    function automatic logic [63:0] dv(input int n);
        return 64'hD000_0000_0000_0000 | 64'(n);
    endfunction

    // Asynchronous reset mid-cycle with busy inputs; outputs must clear at once.
    task automatic apply_reset();
        en = 1'b1; fv = 1'b1; fa = 32'h123; rtag = 4'h7; stag = '0; sdata = '1;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_hit",   64'(o_fetch_hit),     64'd0);
        check("rst_rv",    64'(o_mem_req_valid), 64'd0);
        check("rst_addr",  64'(o_mem_req_addr),  64'd0);
        check("rst_occ",   64'(o_occupancy),     64'd0);
        check("rst_data",  o_fetch_data,         64'd0);
        repeat (2) @(posedge clk);
        en = 1'b0; fv = 1'b0; fa = '0; rtag = '0; sdata = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    pf_entry_t         mq[$];
    pf_entry_t         me;
    logic [ADDR_W-1:0] m_next;
    bit   [15:0]       outst;
    int                cand[16];
    int                n_cand;
    logic              m_empty, m_full, m_redirect, m_hit, m_rv;
    logic [DATA_W-1:0] m_data;
    vec_t              v;

    initial begin
        // Sequential fill to full, out-of-order responses, hit/ack collision when full.
        add(1,1,1,32'h0,  1,0,0,          0,0,      1,32'h00,0);
        add(0,1,1,32'h0,  2,0,0,          0,0,      1,32'h08,1);
        add(0,1,1,32'h0,  3,0,0,          0,0,      1,32'h10,2);
        add(0,1,1,32'h0,  4,0,0,          0,0,      1,32'h18,3);
        add(0,1,1,32'h0,  5,0,0,          0,0,      1,32'h20,4);
        add(0,1,1,32'h0,  6,0,0,          0,0,      1,32'h28,5);
        add(0,1,1,32'h0,  7,0,0,          0,0,      1,32'h30,6);
        add(0,1,1,32'h0,  8,0,0,          0,0,      1,32'h38,7);
        add(0,1,1,32'h0,  9,0,0,          0,0,      0,32'h40,8);
        add(0,1,1,32'h0,  0,3,dv(3),      0,0,      0,32'h40,8);
        add(0,1,1,32'h0,  0,1,dv(1),      0,0,      0,32'h40,8);
        add(0,1,1,32'h0,  9,2,dv(2),      1,dv(1),  0,32'h40,8);
        add(0,1,1,32'h8,  9,0,0,          1,dv(2),  1,32'h40,7);
        add(0,1,0,32'h0,  10,0,0,         0,0,      1,32'h48,7);
        add(0,1,0,32'h0,  0,0,0,          0,0,      0,32'h50,8);
        add(0,1,1,32'h10, 0,0,0,          1,dv(3),  0,32'h50,8);
        add(0,1,0,32'h0,  0,0,0,          0,0,      1,32'h50,7);
        // Redirect with a line still in flight; its late response is dropped.
        add(1,0,1,32'h100,0,0,0,          0,0,      0,32'h0,0);
        add(0,1,0,32'h0,  1,0,0,          0,0,      1,32'h100,0);
        add(0,1,0,32'h0,  2,0,0,          0,0,      1,32'h108,1);
        add(0,1,0,32'h0,  3,0,0,          0,0,      1,32'h110,2);
        add(0,1,0,32'h0,  4,0,0,          0,0,      1,32'h118,3);
        add(0,0,0,32'h0,  0,1,dv(17),     0,0,      0,32'h120,4);
        add(0,0,0,32'h0,  0,3,dv(19),     0,0,      0,32'h120,4);
        add(0,0,0,32'h0,  0,4,dv(20),     0,0,      0,32'h120,4);
        add(0,1,1,32'h400,5,0,0,          0,0,      0,32'h120,4);
        add(0,1,0,32'h0,  5,0,0,          0,0,      1,32'h400,0);
        add(0,0,1,32'h400,0,2,dv(34),     0,0,      0,32'h408,1);
        add(0,0,1,32'h400,0,0,0,          0,0,      0,32'h408,1);
        add(0,0,1,32'h400,0,5,dv(85),     0,0,      0,32'h408,1);
        add(0,0,1,32'h400,0,0,0,          1,dv(85), 0,32'h408,1);
        add(0,0,0,32'h0,  0,0,0,          0,0,      0,32'h408,0);
        // Address wrap at the top of the space; tag 0 holds the request.
        add(1,0,1,32'hFFFFFFF8,0,0,0,     0,0,      0,32'h0,0);
        add(0,1,0,32'h0,  1,0,0,          0,0,      1,32'hFFFFFFF8,0);
        add(0,1,0,32'h0,  0,0,0,          0,0,      1,32'h0,1);
        add(0,1,0,32'h0,  0,0,0,          0,0,      1,32'h0,1);
        add(0,1,0,32'h0,  2,0,0,          0,0,      1,32'h0,1);
        add(0,0,0,32'h0,  0,0,0,          0,0,      0,32'h8,2);
        // Reset with five lines pending; their tags arriving afterwards are dropped.
        add(1,1,0,32'h0,  1,0,0,          0,0,      1,32'h00,0);
        add(0,1,0,32'h0,  2,0,0,          0,0,      1,32'h08,1);
        add(0,1,0,32'h0,  3,0,0,          0,0,      1,32'h10,2);
        add(0,1,0,32'h0,  4,0,0,          0,0,      1,32'h18,3);
        add(0,1,0,32'h0,  5,0,0,          0,0,      1,32'h20,4);
        add(0,0,0,32'h0,  0,0,0,          0,0,      0,32'h28,5);
        add(1,0,0,32'h0,  0,1,dv(153),    0,0,      0,32'h0,0);
        add(0,0,0,32'h0,  0,2,dv(153),    0,0,      0,32'h0,0);
        add(0,0,0,32'h0,  0,3,dv(153),    0,0,      0,32'h0,0);
        add(0,0,0,32'h0,  0,4,dv(153),    0,0,      0,32'h0,0);
        add(0,0,0,32'h0,  0,5,dv(153),    0,0,      0,32'h0,0);
        add(0,1,0,32'h0,  6,0,0,          0,0,      1,32'h0,0);
        add(0,0,1,32'h0,  0,0,0,          0,0,      0,32'h8,1);
        add(0,0,1,32'h0,  0,6,dv(102),    0,0,      0,32'h8,1);
        add(0,0,1,32'h0,  0,0,0,          1,dv(102),0,32'h8,1);

        rst_n = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            if (v.rst) apply_reset();
            en = v.en; fv = v.fv; fa = v.fa; rtag = v.rtag; stag = v.stag; sdata = v.sdata;
            @(negedge clk);
            check($sformatf("v%0d_hit", i),  64'(o_fetch_hit),     64'(v.e_hit));
            check($sformatf("v%0d_rv", i),   64'(o_mem_req_valid), 64'(v.e_rv));
            check($sformatf("v%0d_addr", i), 64'(o_mem_req_addr),  64'(v.e_addr));
            check($sformatf("v%0d_occ", i),  64'(o_occupancy),     64'(v.e_occ));
            if (v.e_hit) check($sformatf("v%0d_data", i), o_fetch_data, v.e_data);
            $display("[TB] vec %0d fv=%0b fa=%h ack=%0d resp=%0d hit=%0b req=%0b addr=%h occ=%0d",
                     i, fv, fa, rtag, stag, o_fetch_hit, o_mem_req_valid, o_mem_req_addr, o_occupancy);
            @(posedge clk);
            #1;
        end

        // Randomized traffic against an in-order queue model of the prefetcher.
        apply_reset();
        mq.delete();
        m_next = '0;
        outst  = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            en = ($urandom_range(0, 9) < 8);
            fv = ($urandom_range(0, 9) < 6);
            fa = (mq.size() > 0) ? mq[0].addr : m_next;
            if ($urandom_range(0, 24) == 0) fa = 32'h1000 + 32'($urandom_range(0, 63)) * 32'd8;
            rtag = '0;
            if ($urandom_range(0, 9) < 7) begin
                n_cand = 0;
                for (int t = 1; t < 16; t++) if (!outst[t]) begin cand[n_cand] = t; n_cand++; end
                if (n_cand > 0) rtag = 4'(cand[$urandom_range(0, n_cand - 1)]);
            end
            stag  = '0;
            sdata = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) begin
                n_cand = 0;
                for (int t = 1; t < 16; t++) if (outst[t]) begin cand[n_cand] = t; n_cand++; end
                if (n_cand > 0) stag = 4'(cand[$urandom_range(0, n_cand - 1)]);
            end else if ($urandom_range(0, 19) == 0) begin
                n_cand = 0;
                for (int t = 1; t < 16; t++) if (!outst[t]) begin cand[n_cand] = t; n_cand++; end
                if (n_cand > 0) stag = 4'(cand[$urandom_range(0, n_cand - 1)]);
            end

            m_empty = (mq.size() == 0);
            m_full  = (mq.size() == DEPTH);
            m_hit   = 1'b0;
            m_data  = '0;
            if (m_empty) begin
                m_redirect = fv && (fa != m_next);
            end else begin
                m_redirect = fv && (mq[0].addr != fa);
                m_hit      = fv && (mq[0].state == ST_READY) && (mq[0].addr == fa);
                m_data     = mq[0].data;
            end
            m_rv = en && !m_full && !m_redirect;

            @(negedge clk);
            check($sformatf("r%0d_hit", cyc),  64'(o_fetch_hit),     64'(m_hit));
            check($sformatf("r%0d_rv", cyc),   64'(o_mem_req_valid), 64'(m_rv));
            check($sformatf("r%0d_addr", cyc), 64'(o_mem_req_addr),  64'(m_next));
            check($sformatf("r%0d_occ", cyc),  64'(o_occupancy),     64'(mq.size()));
            if (m_hit) check($sformatf("r%0d_data", cyc), o_fetch_data, m_data);
            $display("[TB] rnd %0d fv=%0b fa=%h ack=%0d resp=%0d hit=%0b req=%0b addr=%h occ=%0d",
                     cyc, fv, fa, rtag, stag, o_fetch_hit, o_mem_req_valid, o_mem_req_addr, o_occupancy);

            if (m_redirect) begin
                mq.delete();
                m_next = fa;
            end else begin
                if (stag != 0) begin
                    for (int i = 0; i < mq.size(); i++) begin
                        if (mq[i].state == ST_PENDING && mq[i].tag == stag) begin
                            me = mq[i];
                            me.state = ST_READY;
                            me.data  = sdata;
                            mq[i] = me;
                            break;
                        end
                    end
                end
                if (m_hit) void'(mq.pop_front());
                if (m_rv && rtag != 0) begin
                    me.addr  = m_next;
                    me.tag   = rtag;
                    me.data  = '0;
                    me.state = ST_PENDING;
                    mq.push_back(me);
                    m_next = m_next + 32'(STRIDE);
                    outst[rtag] = 1'b1;
                end
            end
            if (stag != 0) outst[stag] = 1'b0;

            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_prefetch_queue.md
INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

Interface
REQ-001 The block SHALL have parameters: DEPTH, default 8, entry count (power of two, 4..16); ADDR_W, default 32, address width; DATA_W, default 64, line data width; TAG_W, default 4, memory tag width; STRIDE, default 8, byte increment between sequential prefetches.
REQ-002 The block SHALL have these ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  permits new prefetch issue.
- fetch_valid  in  1  demand fetch present.
- fetch_addr  in  ADDR_W  demand fetch address.
- fetch_hit  out  1  demand served this cycle.
- fetch_data  out  DATA_W  line for the demand fetch; valid only when fetch_hit=1.
- mem_req_valid  out  1  prefetch request.
- mem_req_addr  out  ADDR_W  prefetch address.
- mem_req_tag  in  TAG_W  tag from the controller; nonzero means the request was accepted this cycle.
- mem_resp_tag  in  TAG_W  response tag; 0 means no response.
- mem_resp_data  in  DATA_W  response data.
- occupancy  out  $clog2(DEPTH)+1  live entry count.

Function
REQ-003 The block SHALL be a circular queue of DEPTH entries. Each entry SHALL hold addr, tag, data and a state from EMPTY, PENDING, READY.
REQ-004 Head and tail pointers SHALL each be $clog2(DEPTH)+1 bits. Full SHALL be defined as same index with opposite MSB; empty SHALL be defined as pointers equal.
REQ-005 mem_req_valid SHALL equal enable AND not full AND no redirect this cycle. mem_req_addr SHALL equal next_addr.
REQ-006 On mem_req_valid=1 with mem_req_tag!=0, the block SHALL do all of the following:
- write the tail entry as PENDING with addr=next_addr and tag=mem_req_tag;
- increment tail;
- set next_addr to next_addr+STRIDE, modulo 2^ADDR_W.
REQ-007 When mem_req_tag=0, the block SHALL hold next_addr and mem_req_addr unchanged.
REQ-008 A nonzero mem_resp_tag equal to the tag of a PENDING entry SHALL set that entry READY and capture mem_resp_data. A nonzero mem_resp_tag matching no PENDING entry SHALL be discarded.
REQ-009 fetch_hit SHALL be combinational: fetch_valid AND not empty AND head READY AND head addr==fetch_addr. fetch_data SHALL be the head data.
REQ-010 On fetch_hit, the block SHALL set the head entry EMPTY and increment head at the clock edge.
REQ-011 On fetch_valid with head PENDING and addr match, the block SHALL hold fetch_hit=0 with no state change (stall).
REQ-012 A redirect SHALL occur when fetch_valid=1 and either:
- not empty and head addr!=fetch_addr; or
- empty and fetch_addr!=next_addr.
REQ-013 On a redirect edge, the block SHALL set all entries EMPTY, set head=tail=0, and set next_addr=fetch_addr.
REQ-014 A response arriving in the redirect cycle SHALL be ignored.
REQ-015 Full SHALL be evaluated before any same-cycle pop. A pop SHALL NOT enable an allocation in the same cycle.
REQ-016 Simultaneous allocate and pop SHALL leave occupancy unchanged.
REQ-017 A response for the head entry SHALL NOT bypass to fetch_hit in the same cycle; the hit SHALL appear no earlier than the next cycle.
REQ-018 The block SHALL rely on the memory controller never reissuing a tag still outstanding from a flushed entry, so a stale response SHALL never match a new entry.
REQ-019 occupancy SHALL equal tail-head, modulo 2*DEPTH.

Reset
REQ-020 While reset=0, asynchronously: all entries SHALL be EMPTY; head, tail and next_addr SHALL be 0; mem_req_valid, fetch_hit and occupancy SHALL be 0; fetch_data and mem_req_addr SHALL be 0.
REQ-021 Assertion of reset mid-operation SHALL drop all outstanding entries; responses arriving after release SHALL be discarded per REQ-008.

Structure
REQ-022 Package prefetch_pkg SHALL hold the entry-state enum, the entry struct type and the default parameter constants.
REQ-023 Tag matching across entries SHALL be a sub-module pf_tag_cam. Its input SHALL be entry tags and states plus mem_resp_tag; its outputs SHALL be a one-hot match vector and a match-valid flag.

Verification
REQ-024 Scenario: DEPTH=8, STRIDE=8; release reset; fetch 0x0; controller acks with tags 1..8 -> the block SHALL issue addresses 0x0..0x38 and SHALL stop at occupancy 8.
REQ-025 Scenario: responses arrive out of order (tag 3, then 1, then 2); fetch 0x0 -> fetch_hit=1 only after the tag-1 response, and the hit SHALL occur one cycle after that response.
REQ-026 Scenario: queue holds 0x100..0x118 with 0x108 in flight; fetch 0x400 -> redirect; occupancy SHALL be 0 next cycle; next mem_req_addr SHALL be 0x400; a later tag-2 response SHALL be discarded.
REQ-027 Scenario: full queue; fetch hit on head in the same cycle as an ack -> no allocation that cycle; occupancy SHALL be 7, then 8 after the next ack.
REQ-028 Scenario: next_addr=0xFFFFFFF8 -> the following issued address SHALL be 0x00000000.
REQ-029 Scenario: assert reset with 5 entries PENDING; release; inject the old tags -> no entry SHALL become READY and occupancy SHALL remain 0.
